// File: rtl/qhy_mac_stream.sv
// Streaming complex MAC: z = sum over N beats of y_k * conj(q_k), valid/ready on input and output.
// Build option: define QHY_MAC_SAT_EN to saturate z on overflow and add the sticky sat_flag output.
module qhy_mac_stream #(
    parameter int W    = 28,
    parameter int N    = 4,
    parameter int FRAC = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [W-1:0]   y_real,
    input  logic signed [W-1:0]   y_imag,
    input  logic signed [W-1:0]   q_real,
    input  logic signed [W-1:0]   q_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [W-1:0]   z_real,
    output logic signed [W-1:0]   z_imag,
    output logic [$clog2(N)-1:0]  beat_idx
`ifdef QHY_MAC_SAT_EN
    ,
    output logic                  sat_flag
`endif
);
    localparam int CW    = $clog2(N);
    localparam int PW    = 2 * W;
    localparam int PRW   = 2 * W + 1;
    localparam int ACC_W = 2 * W + 1 + CW;
    localparam int HI    = FRAC + W - 1;

    logic signed [PW-1:0]    w_p_rr, w_p_ii, w_p_ir, w_p_ri;
    logic signed [PRW-1:0]   w_pr, w_pi;
    logic signed [ACC_W-1:0] w_sum_re, w_sum_im;
    logic signed [ACC_W-1:0] r_acc_re, r_acc_im;
    logic [CW-1:0]           r_cnt;
    logic                    r_out_valid;
    logic signed [W-1:0]     r_z_re, r_z_im;
    logic                    w_last, w_accept, w_out_fire;

`ifdef QHY_MAC_SAT_EN
    // Overflow when the bits above the output MSB are not a pure sign extension.
    function automatic logic ovf(input logic signed [ACC_W-1:0] s);
        return !((&s[ACC_W-1:HI]) || !(|s[ACC_W-1:HI]));
    endfunction
`endif

    function automatic logic signed [W-1:0] reduce(input logic signed [ACC_W-1:0] s);
`ifdef QHY_MAC_SAT_EN
        if (ovf(s))
            return s[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return s[HI:FRAC];
    endfunction

    // Operands are widened first so every product is exact.
    assign w_p_rr   = PW'(y_real) * PW'(q_real);
    assign w_p_ii   = PW'(y_imag) * PW'(q_imag);
    assign w_p_ir   = PW'(y_imag) * PW'(q_real);
    assign w_p_ri   = PW'(y_real) * PW'(q_imag);
    assign w_pr     = PRW'(w_p_rr) + PRW'(w_p_ii);
    assign w_pi     = PRW'(w_p_ir) - PRW'(w_p_ri);
    assign w_sum_re = r_acc_re + ACC_W'(w_pr);
    assign w_sum_im = r_acc_im + ACC_W'(w_pi);

    // Only the closing beat needs a free output slot; earlier beats of the next vector may proceed.
    assign w_last     = (r_cnt == CW'(N - 1));
    assign in_ready   = !(w_last && r_out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready && !clr;
    assign w_out_fire = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_z_re      <= '0;
            r_z_im      <= '0;
        end else begin
            // NOTE: non-blocking assignments let the later capture override the handshake clear below.
            if (w_out_fire)
                r_out_valid <= 1'b0;
            if (clr) begin
                r_acc_re <= '0;
                r_acc_im <= '0;
                r_cnt    <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_z_re      <= reduce(w_sum_re);
                    r_z_im      <= reduce(w_sum_im);
                    r_out_valid <= 1'b1;
                    r_acc_re    <= '0;
                    r_acc_im    <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc_re <= w_sum_re;
                    r_acc_im <= w_sum_im;
                    r_cnt    <= r_cnt + CW'(1);
                end
            end
        end
    end

`ifdef QHY_MAC_SAT_EN
    logic r_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat <= 1'b0;
        else if (clr)
            r_sat <= 1'b0;
        else if (w_accept && w_last && (ovf(w_sum_re) || ovf(w_sum_im)))
            r_sat <= 1'b1;
    end

    assign sat_flag = r_sat;
`endif

    assign out_valid = r_out_valid;
    assign z_real    = r_z_re;
    assign z_imag    = r_z_im;
    assign beat_idx  = r_cnt;

endmodule
